noc_vchannel_sched: RTL and testbench

NOC_VCHANNEL_SCHED -- requirements
Module: noc_vchannel_sched

---
 rtl/noc_vchannel_pkg.sv | 19 +
 rtl/arb_rr.sv | 33 +++
 rtl/noc_vchannel_sched.sv | 131 +++++++++++++
 tb/tb_noc_vchannel_sched.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/noc_vchannel_pkg.sv
// Shared types and sizing helpers for the virtual-channel scheduler.
package noc_vchannel_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } sched_state_e;

  // Width able to hold every value 0..credits inclusive.
  function automatic int unsigned credit_width(input int unsigned credits);
    return (credits < 1) ? 1 : $clog2(credits + 1);
  endfunction

  // Width of an index into n channels, never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/arb_rr.sv
// Combinational round-robin picker; the request after i_last has top priority.
module arb_rr
  import noc_vchannel_pkg::*;
#(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = idx_width(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic [N-1:0]  o_grant_c,
  output logic [IW-1:0] o_grant_idx_c,
  output logic          o_any_c
);

  int unsigned w_idx;

  always_comb begin
    o_grant_c     = '0;
    o_grant_idx_c = '0;
    o_any_c       = 1'b0;
    w_idx         = 0;
    // Walk the ring once, starting just past the last served channel.
    for (int unsigned k = 1; k <= N; k++) begin
      w_idx = (32'(i_last) + k) % N;
      if (!o_any_c && i_req[IW'(w_idx)]) begin
        o_any_c                = 1'b1;
        o_grant_c[IW'(w_idx)]  = 1'b1;
        o_grant_idx_c          = IW'(w_idx);
      end
    end
  end

endmodule

// File: rtl/noc_vchannel_sched.sv
// Credit-based virtual-channel scheduler: locks one VC per packet and
// round-robins between packets, with a bubble cycle after each packet.
module noc_vchannel_sched
  import noc_vchannel_pkg::*;
#(
  parameter int unsigned CHANNELS = 7,
  parameter int unsigned CREDITS  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] in_valid,
  input  logic [CHANNELS-1:0] in_last,
  output logic [CHANNELS-1:0] in_ready,
  input  logic [CHANNELS-1:0] credit_ret,
  output logic [CHANNELS-1:0] select,
  output logic                out_valid,
  output logic                credit_err
);

  localparam int unsigned CW = credit_width(CREDITS);
  localparam int unsigned IW = idx_width(CHANNELS);
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

  sched_state_e                 r_state;
  sched_state_e                 w_state_nxt;
  logic [CHANNELS-1:0]          r_select;
  logic [CHANNELS-1:0]          w_select_nxt;
  logic [IW-1:0]                r_gidx;
  logic [IW-1:0]                w_gidx_nxt;
  logic [IW-1:0]                r_last;
  logic [IW-1:0]                w_last_nxt;
  logic [CHANNELS-1:0][CW-1:0]  r_credit;
  logic [CHANNELS-1:0][CW-1:0]  w_credit_nxt;
  logic                         r_credit_err;
  logic                         w_err_nxt;

  logic [CHANNELS-1:0]          w_has_credit;
  logic [CHANNELS-1:0]          w_full;
  logic [CHANNELS-1:0]          w_ovf;
  logic [CHANNELS-1:0]          w_eligible;
  logic [CHANNELS-1:0]          w_ready;
  logic [CHANNELS-1:0]          w_xfer;
  logic                         w_pkt_end;
  logic [CHANNELS-1:0]          w_pick;
  logic [IW-1:0]                w_pick_idx;
  logic                         w_pick_any;

  // Per-VC credit bookkeeping; a simultaneous send and return cancel out.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_vc
    assign w_has_credit[c] = |r_credit[c];
    assign w_full[c]       = (r_credit[c] == CRED_MAX);
    assign w_ovf[c]        = credit_ret[c] & ~w_xfer[c] & w_full[c];
    assign w_credit_nxt[c] =
        (w_xfer[c] & ~credit_ret[c])               ? r_credit[c] - CW'(1) :
        (credit_ret[c] & ~w_xfer[c] & ~w_full[c])  ? r_credit[c] + CW'(1) :
                                                     r_credit[c];
  end

  assign w_eligible = in_valid & w_has_credit;
  assign w_err_nxt  = r_credit_err | (|w_ovf);

  // Readiness uses only the registered credit count.
  assign w_ready    = (r_state == GRANT && !rst) ? (r_select & w_has_credit) : '0;
  assign w_xfer     = in_valid & w_ready;
  assign w_pkt_end  = |(w_xfer & in_last);

  arb_rr #(
    .N (CHANNELS)
  ) u_arb (
    .i_req         (w_eligible),
    .i_last        (r_last),
    .o_grant_c     (w_pick),
    .o_grant_idx_c (w_pick_idx),
    .o_any_c       (w_pick_any)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_select_nxt = r_select;
    w_gidx_nxt   = r_gidx;
    w_last_nxt   = r_last;
    case (r_state)
      IDLE: begin
        w_select_nxt = '0;
        if (w_pick_any) begin
          w_state_nxt  = GRANT;
          w_select_nxt = w_pick;
          w_gidx_nxt   = w_pick_idx;
        end
      end
      GRANT: begin
        // Held on the same VC until its last flit moves; no timeout.
        if (w_pkt_end) begin
          w_state_nxt  = IDLE;
          w_select_nxt = '0;
          w_last_nxt   = r_gidx;
        end
      end
      default: begin
        w_state_nxt  = IDLE;
        w_select_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_select     <= '0;
      r_gidx       <= '0;
      r_last       <= IW'(CHANNELS - 1);
      r_credit_err <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        r_credit[c] <= CRED_MAX;
      end
    end else begin
      r_state      <= w_state_nxt;
      r_select     <= w_select_nxt;
      r_gidx       <= w_gidx_nxt;
      r_last       <= w_last_nxt;
      r_credit     <= w_credit_nxt;
      r_credit_err <= w_err_nxt;
    end
  end

  assign in_ready   = w_ready;
  assign select     = r_select;
  assign out_valid  = |w_xfer;
  assign credit_err = r_credit_err;

endmodule

// File: tb/tb_noc_vchannel_sched.sv
// Bench for noc_vchannel_sched: directed scenarios plus random traffic against a packet-level model.
module tb_noc_vchannel_sched;

  localparam int unsigned N  = 3;
  localparam int unsigned CR = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] in_valid;
  logic [N-1:0] in_last;
  logic [N-1:0] in_ready;
  logic [N-1:0] credit_ret;
  logic [N-1:0] select;
  logic         out_valid;
  logic         credit_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: which VC owns the output (-1 none), last finished VC, credits, sticky error.
  int   m_owner;
  int   m_last;
  int   m_cred [N];
  logic m_err;

  logic [N-1:0] s_sel;
  logic [N-1:0] s_rdy;
  logic         s_ov;
  logic         s_err;
  int           rr_seen [8];
  int           rr_exp  [8] = '{0, 1, 0, 2, 0, 4, 0, 1};

  noc_vchannel_sched #(
    .CHANNELS (N),
    .CREDITS  (CR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .credit_ret (credit_ret),
    .select     (select),
    .out_valid  (out_valid),
    .credit_err (credit_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = N - 1;
    for (int i = 0; i < N; i++) m_cred[i] = CR;
    m_err = 1'b0;
  endtask

  // One clock: drive, check outputs mid-low-phase, advance model, check credits after edge.
  task automatic cycle(input logic [N-1:0] v, input logic [N-1:0] l, input logic [N-1:0] cr);
    logic [N-1:0] e_sel;
    logic [N-1:0] e_rdy;
    logic         e_ov;
    logic         xfer;
    int           nxt;
    int           idx;
    @(negedge clk);
    in_valid   = v;
    in_last    = l;
    credit_ret = cr;
    #1;
    e_sel = '0;
    e_rdy = '0;
    e_ov  = 1'b0;
    if (m_owner >= 0) begin
      e_sel[m_owner] = 1'b1;
      if (m_cred[m_owner] > 0) e_rdy[m_owner] = 1'b1;
      e_ov = v[m_owner] & e_rdy[m_owner];
    end
    s_sel = select;
    s_rdy = in_ready;
    s_ov  = out_valid;
    s_err = credit_err;
    chk("select",     32'(s_sel), 32'(e_sel));
    chk("in_ready",   32'(s_rdy), 32'(e_rdy));
    chk("out_valid",  32'(s_ov),  32'(e_ov));
    chk("credit_err", 32'(s_err), 32'(m_err));
    nxt = m_owner;
    if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        idx = (m_last + k) % N;
        if (nxt < 0 && v[idx] && m_cred[idx] > 0) nxt = idx;
      end
    end else if (e_ov && l[m_owner]) begin
      m_last = m_owner;
      nxt    = -1;
    end
    for (int c = 0; c < N; c++) begin
      xfer = e_ov && (m_owner == c);
      if (xfer && !cr[c]) m_cred[c] = m_cred[c] - 1;
      else if (!xfer && cr[c]) begin
        if (m_cred[c] == CR) m_err = 1'b1;
        else m_cred[c] = m_cred[c] + 1;
      end
    end
    m_owner = nxt;
    @(posedge clk);
    #1;
    for (int c = 0; c < N; c++) begin
      chk($sformatf("credit%0d", c), 32'(dut.r_credit[c]), 32'(m_cred[c]));
    end
  endtask

  // Assert reset with current inputs still applied; outputs must clear at once.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_select",    32'(select),     32'(0));
    chk("rst_in_ready",  32'(in_ready),   32'(0));
    chk("rst_out_valid", 32'(out_valid),  32'(0));
    chk("rst_err",       32'(credit_err), 32'(0));
    for (int c = 0; c < N; c++) begin
      chk($sformatf("rst_credit%0d", c), 32'(dut.r_credit[c]), 32'(CR));
    end
    @(negedge clk);
    #1;
    chk("rst_hold_ready", 32'(in_ready),  32'(0));
    chk("rst_hold_ov",    32'(out_valid), 32'(0));
    in_valid   = '0;
    in_last    = '0;
    credit_ret = '0;
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = '0;
    in_last    = '0;
    credit_ret = '0;
    model_reset();
    do_reset();

    // Single 2-flit packet on VC1 drains its credits.
    cycle(3'b010, 3'b000, 3'b000);
    chk("sc1_idle_sel", 32'(s_sel), 32'(3'b000));
    cycle(3'b010, 3'b000, 3'b000);
    chk("sc1_sel", 32'(s_sel), 32'(3'b010));
    chk("sc1_ov1", 32'(s_ov),  32'(1));
    cycle(3'b010, 3'b010, 3'b000);
    chk("sc1_ov2",   32'(s_ov),             32'(1));
    chk("sc1_cred1", 32'(dut.r_credit[1]), 32'(0));
    cycle(3'b000, 3'b000, 3'b000);
    chk("sc1_idle_after", 32'(s_sel), 32'(3'b000));

    // Credit stall on the third flit, released by one returned credit.
    do_reset();
    cycle(3'b010, 3'b000, 3'b000);
    cycle(3'b010, 3'b000, 3'b000);
    cycle(3'b010, 3'b000, 3'b000);
    cycle(3'b010, 3'b010, 3'b000);
    chk("sc2_stall_rdy", 32'(s_rdy), 32'(3'b000));
    chk("sc2_stall_sel", 32'(s_sel), 32'(3'b010));
    cycle(3'b010, 3'b010, 3'b010);
    chk("sc2_ret_rdy", 32'(s_rdy), 32'(3'b000));
    cycle(3'b010, 3'b010, 3'b000);
    chk("sc2_resume_ov",  32'(s_ov),  32'(1));
    chk("sc2_resume_rdy", 32'(s_rdy), 32'(3'b010));
    cycle(3'b000, 3'b000, 3'b000);

    // Round robin over three single-flit streams, bubble between grants.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cycle(3'b111, 3'b111, 3'b000);
      rr_seen[i] = 32'(s_sel);
    end
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("sc3_rr%0d", i), 32'(rr_seen[i]), 32'(rr_exp[i]));
    end

    // Packet lock on VC0 with VC2 waiting; then overflow on a full VC1.
    do_reset();
    cycle(3'b101, 3'b000, 3'b000);
    cycle(3'b101, 3'b000, 3'b001);
    chk("sc4_sel_f1",  32'(s_sel),             32'(3'b001));
    chk("sc4_simul",   32'(dut.r_credit[0]),   32'(2));
    cycle(3'b101, 3'b000, 3'b000);
    chk("sc4_sel_f2",  32'(s_sel), 32'(3'b001));
    cycle(3'b101, 3'b001, 3'b000);
    chk("sc4_sel_f3",  32'(s_sel), 32'(3'b001));
    chk("sc4_ov_f3",   32'(s_ov),  32'(1));
    cycle(3'b101, 3'b001, 3'b000);
    chk("sc4_bubble",  32'(s_sel), 32'(3'b000));
    cycle(3'b101, 3'b001, 3'b000);
    chk("sc4_switch",  32'(s_sel), 32'(3'b100));
    cycle(3'b000, 3'b000, 3'b010);
    chk("sc4_ovf_cred", 32'(dut.r_credit[1]), 32'(2));
    cycle(3'b000, 3'b000, 3'b000);
    chk("sc4_err", 32'(s_err), 32'(1));

    // Reset in the middle of a 3-flit packet, then arbitration restarts at VC0.
    do_reset();
    cycle(3'b001, 3'b000, 3'b000);
    cycle(3'b001, 3'b000, 3'b000);
    chk("sc5_f1_ov", 32'(s_ov), 32'(1));
    in_valid = 3'b001;
    do_reset();
    cycle(3'b111, 3'b000, 3'b000);
    cycle(3'b111, 3'b000, 3'b000);
    chk("sc5_restart", 32'(s_sel), 32'(3'b001));

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cycle(N'($urandom), N'($urandom),
            ($urandom_range(0, 2) == 0) ? N'($urandom) : N'(0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
